aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
Round scheduler for the AES core. It starts key expansion in the key memory, waits for it to finish, then accepts plaintext blocks over a valid/ready handshake. For each block it drives the key memory round index and the round datapath enables for one round per cycle, then holds the result until the consumer accepts it. It sits between the core's top-level interface, the key memory (round-key store with a combinational read) and the round datapath.

Parameters:
KEYEXP_TIMEOUT, 32, maximum cycles spent waiting for km_ready after km_init; legal range 20..255.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
key_init  input  1  request key expansion; single-cycle pulse
keylen  input  1  key length, sampled with key_init: 0 = 128-bit (Nr=10), 1 = 256-bit (Nr=14)
km_init  output  1  one-cycle init pulse to the key memory
km_ready  input  1  key memory expansion done
km_round  output  4  round index driven to the key memory read port
blk_valid  input  1  plaintext block available
blk_ready  output  1  scheduler accepts a block
dp_load  output  1  datapath loads the block and applies round key 0
dp_round_en  output  1  datapath performs one round with the current round key
dp_final  output  1  current round is the last one (MixColumns skipped)
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result
key_valid  output  1  an expanded key is present
key_err  output  1  key-expansion timeout occurred; sticky

Behaviour:
- Reset: state NOKEY. All outputs 0. keylen_reg=0, pending=0, timeout counter=0. A reset during any operation aborts it; km_init is not reissued after reset.
- States:
  - NOKEY: waits for key_init.
  - KSTART: km_init=1 for one cycle; goes to KWAIT0.
  - KWAIT0: km_ready is ignored for this cycle, because the key memory still shows its old ready value; goes to KWAIT.
  - KWAIT: leaves when km_ready=1.
  - READY: waits for a block or a rekey.
  - LOAD, ROUND, FINAL: per-block round sequence.
  - OUT: holds the result.
- key_init accepted in NOKEY or READY: latch keylen into keylen_reg, clear key_err and key_valid, go to KSTART.
- KWAIT: km_ready=1 -> READY with key_valid=1. If the counter reaches KEYEXP_TIMEOUT -> NOKEY with key_err=1. The counter clears in KSTART and increments in KWAIT0 and KWAIT.
- blk_ready=1 only in READY when key_init=0. If key_init and blk_valid arrive in the same cycle, key_init wins and the block is not accepted.
- Block handshake (blk_valid & blk_ready) -> LOAD.
- LOAD: km_round=0, dp_load=1.
- ROUND: km_round runs 1..Nr-1 on consecutive cycles with dp_round_en=1.
- FINAL: km_round=Nr, dp_round_en=1, dp_final=1.
- OUT: res_valid=1, held until res_ready.
- Latency: with the handshake in cycle 0, res_valid is first high in cycle Nr+2 (12 for AES-128, 16 for AES-256). Back-to-back throughput is one block per Nr+3 cycles when res_ready is held high.
- km_round is 0 in all non-round states. The round counter is 4 bits and never wraps: the sequence ends at Nr, and Nr is at most 14.
- key_init during KSTART..OUT (except READY): sets pending, which is sticky, and latches keylen. At the res_valid&res_ready handshake: pending=1 -> clear pending, go to KSTART; otherwise go to READY. A block in flight always finishes with the old key.
- key_valid=1 in READY, LOAD, ROUND, FINAL and OUT. It drops to 0 on entry to KSTART.
- Nr is taken from keylen_reg only, never from the live keylen input.

Optional Feature:
AES_SCHED_DECRYPT_EN
- When defined: adds an input blk_dec (1 bit), sampled at the block handshake.
  - blk_dec=1: LOAD uses km_round=Nr, ROUND counts Nr-1 down to 1, FINAL uses km_round=0. Latency is unchanged.
  - Also adds an output dp_dec, equal to the latched blk_dec during LOAD..OUT, so the datapath selects its inverse transforms.
- When undefined: no blk_dec or dp_dec ports; encrypt order only.

Test Plan:
- Key load: rst high for 2 cycles, then key_init with keylen=0 -> km_init high exactly 1 cycle later for 1 cycle. Model km_ready low for 12 cycles then high -> key_valid=1 and blk_ready=1 in the following cycle.
- AES-128 block: handshake in cycle 0, res_ready=1 -> dp_load in cycle 1 (km_round=0), km_round 1..9 in cycles 2..10, dp_final in cycle 11 (km_round=10), res_valid in cycle 12 for 1 cycle.
- AES-256 with backpressure: keylen=1, res_ready held low for 5 cycles -> km_round reaches 14 in the FINAL cycle, res_valid stays high 6 cycles, blk_ready=0 throughout.
- Rekey mid-block: key_init with keylen=1 in cycle 4 of an AES-128 block -> that block still completes with Nr=10; after the result handshake, km_init pulses and key_valid=0.
- Timeout and collision: km_ready stuck at 0 -> key_err=1 and state NOKEY after 32 cycles; key_init and blk_valid in the same cycle in READY -> block not accepted.
- With AES_SCHED_DECRYPT_EN and blk_dec=1, keylen=0 -> km_round sequence 10,9,...,1,0 with dp_final on 0, and dp_dec=1.

Source files
------------

// File: rtl/aes_round_sched.sv
// ---------------------------------------------------------------------------
// aes_round_sched
//
// Round scheduler for the AES core. It kicks off key expansion in the key
// memory, waits for it to complete (with a timeout), then takes plaintext
// blocks over a valid/ready handshake. For each block it steps the key
// memory round index and the datapath enables one round per cycle, then
// holds the result until the consumer takes it.
//
// Optional feature macro: AES_SCHED_DECRYPT_EN
//   When defined, adds input blk_dec (sampled at the block handshake) and
//   output dp_dec. A decrypt block walks the round keys Nr..0 instead of 0..Nr.
//
// Parameters:
//   KEYEXP_TIMEOUT  max cycles waiting for km_ready after km_init (20..255)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   key_init     request key expansion (single-cycle pulse)
//   keylen       key length, sampled with key_init (0: Nr=10, 1: Nr=14)
//   km_init      one-cycle init pulse to the key memory
//   km_ready     key memory expansion done
//   km_round     round index to the key memory read port
//   blk_valid    plaintext block available
//   blk_dec      (decrypt build only) block is a decryption
//   blk_ready    scheduler accepts a block
//   dp_load      datapath loads the block and applies round key 0 (or Nr)
//   dp_round_en  datapath performs one round
//   dp_final     current round is the last one
//   res_valid    result available
//   res_ready    consumer accepts the result
//   dp_dec       (decrypt build only) datapath uses inverse transforms
//   key_valid    an expanded key is present
//   key_err      sticky key-expansion timeout flag
// ---------------------------------------------------------------------------
module aes_round_sched #(
    parameter int KEYEXP_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_init,
    input  logic       keylen,
    output logic       km_init,
    input  logic       km_ready,
    output logic [3:0] km_round,
    input  logic       blk_valid,
`ifdef AES_SCHED_DECRYPT_EN
    input  logic       blk_dec,
`endif
    output logic       blk_ready,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic       dp_final,
    output logic       res_valid,
    input  logic       res_ready,
`ifdef AES_SCHED_DECRYPT_EN
    output logic       dp_dec,
`endif
    output logic       key_valid,
    output logic       key_err
);

    typedef enum logic [3:0] {
        S_NOKEY,
        S_KSTART,
        S_KWAIT0,
        S_KWAIT,
        S_READY,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_OUT
    } state_t;

    localparam logic [7:0] TMO_CNT = 8'(KEYEXP_TIMEOUT);
    localparam logic [3:0] NR_128  = 4'd10;
    localparam logic [3:0] NR_256  = 4'd14;

    state_t     state_reg, state_next;
    logic       keylen_reg, keylen_next;
    logic       pending_reg, pending_next;
    logic [7:0] tmo_cnt_reg, tmo_cnt_next;
    logic [3:0] step_reg, step_next;     // position in the round sequence, 0..Nr
    logic [3:0] nr_reg, nr_next;         // Nr of the block in flight
    logic       dec_reg, dec_next;
    logic       key_err_reg, key_err_next;
    logic       dec_in;

    // Registered outputs
    logic       km_init_reg;
    logic [3:0] km_round_reg, km_round_next;
    logic       dp_load_reg;
    logic       dp_round_en_reg;
    logic       dp_final_reg;
    logic       res_valid_reg;
    logic       key_valid_reg;
    logic       in_block_next;

`ifdef AES_SCHED_DECRYPT_EN
    logic       dp_dec_reg;
    assign dec_in = blk_dec;
    assign dp_dec = dp_dec_reg;
`else
    assign dec_in = 1'b0;
`endif

    // blk_ready must drop in the same cycle key_init arrives so that a
    // rekey request always wins over a simultaneous block.
    assign blk_ready   = (state_reg == S_READY) && !key_init;

    assign km_init     = km_init_reg;
    assign km_round    = km_round_reg;
    assign dp_load     = dp_load_reg;
    assign dp_round_en = dp_round_en_reg;
    assign dp_final    = dp_final_reg;
    assign res_valid   = res_valid_reg;
    assign key_valid   = key_valid_reg;
    assign key_err     = key_err_reg;

    always_comb begin
        state_next   = state_reg;
        keylen_next  = keylen_reg;
        pending_next = pending_reg;
        tmo_cnt_next = tmo_cnt_reg;
        step_next    = step_reg;
        nr_next      = nr_reg;
        dec_next     = dec_reg;
        key_err_next = key_err_reg;

        // keylen is captured on every key_init; for a deferred rekey it
        // takes effect at the next expansion. The block in flight keeps
        // its own copy of Nr in nr_reg.
        if (key_init) begin
            keylen_next = keylen;
        end
        if (key_init && (state_reg != S_NOKEY) && (state_reg != S_READY)) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            S_NOKEY: begin
                if (key_init) begin
                    key_err_next = 1'b0;
                    pending_next = 1'b0;
                    state_next   = S_KSTART;
                end
            end
            S_KSTART: begin
                tmo_cnt_next = 8'd0;
                state_next   = S_KWAIT0;
            end
            S_KWAIT0: begin
                // km_ready still reflects the previous expansion here.
                tmo_cnt_next = tmo_cnt_reg + 8'd1;
                state_next   = S_KWAIT;
            end
            S_KWAIT: begin
                tmo_cnt_next = tmo_cnt_reg + 8'd1;
                if (km_ready) begin
                    state_next = S_READY;
                end else if (tmo_cnt_next == TMO_CNT) begin
                    key_err_next = 1'b1;
                    state_next   = S_NOKEY;
                end
            end
            S_READY: begin
                if (key_init) begin
                    key_err_next = 1'b0;
                    pending_next = 1'b0;
                    state_next   = S_KSTART;
                end else if (blk_valid) begin
                    step_next  = 4'd0;
                    nr_next    = keylen_reg ? NR_256 : NR_128;
                    dec_next   = dec_in;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                step_next  = 4'd1;
                state_next = S_ROUND;
            end
            S_ROUND: begin
                step_next = step_reg + 4'd1;
                if (step_reg == nr_reg - 4'd1) begin
                    state_next = S_FINAL;
                end
            end
            S_FINAL: begin
                step_next  = 4'd0;
                state_next = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    if (pending_reg || key_init) begin
                        pending_next = 1'b0;
                        state_next   = S_KSTART;
                    end else begin
                        state_next   = S_READY;
                    end
                end
            end
            default: begin
                state_next = S_NOKEY;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        in_block_next = (state_next == S_LOAD) || (state_next == S_ROUND) ||
                        (state_next == S_FINAL);
        km_round_next = 4'd0;
        if (in_block_next) begin
            km_round_next = dec_next ? (nr_next - step_next) : step_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_NOKEY;
            keylen_reg      <= 1'b0;
            pending_reg     <= 1'b0;
            tmo_cnt_reg     <= 8'd0;
            step_reg        <= 4'd0;
            nr_reg          <= NR_128;
            dec_reg         <= 1'b0;
            key_err_reg     <= 1'b0;
            km_init_reg     <= 1'b0;
            km_round_reg    <= 4'd0;
            dp_load_reg     <= 1'b0;
            dp_round_en_reg <= 1'b0;
            dp_final_reg    <= 1'b0;
            res_valid_reg   <= 1'b0;
            key_valid_reg   <= 1'b0;
`ifdef AES_SCHED_DECRYPT_EN
            dp_dec_reg      <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            keylen_reg      <= keylen_next;
            pending_reg     <= pending_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            step_reg        <= step_next;
            nr_reg          <= nr_next;
            dec_reg         <= dec_next;
            key_err_reg     <= key_err_next;
            km_init_reg     <= (state_next == S_KSTART);
            km_round_reg    <= km_round_next;
            dp_load_reg     <= (state_next == S_LOAD);
            dp_round_en_reg <= (state_next == S_ROUND) || (state_next == S_FINAL);
            dp_final_reg    <= (state_next == S_FINAL);
            res_valid_reg   <= (state_next == S_OUT);
            key_valid_reg   <= in_block_next || (state_next == S_READY) ||
                               (state_next == S_OUT);
`ifdef AES_SCHED_DECRYPT_EN
            dp_dec_reg      <= (in_block_next || (state_next == S_OUT)) && dec_next;
`endif
        end
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sched
//
// Directed bench for aes_round_sched: key load, AES-128 and AES-256 blocks,
// result backpressure, rekey collisions, deferred rekey, expansion timeout
// and (with AES_SCHED_DECRYPT_EN) the reversed round-key order.
// ---------------------------------------------------------------------------
module tb_aes_round_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_init;
    logic       keylen;
    logic       km_init;
    logic       km_ready;
    logic [3:0] km_round;
    logic       blk_valid;
    logic       blk_ready;
    logic       dp_load;
    logic       dp_round_en;
    logic       dp_final;
    logic       res_valid;
    logic       res_ready;
    logic       key_valid;
    logic       key_err;
`ifdef AES_SCHED_DECRYPT_EN
    logic       blk_dec;
    logic       dp_dec;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_sched #(.KEYEXP_TIMEOUT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_init    (key_init),
        .keylen      (keylen),
        .km_init     (km_init),
        .km_ready    (km_ready),
        .km_round    (km_round),
        .blk_valid   (blk_valid),
`ifdef AES_SCHED_DECRYPT_EN
        .blk_dec     (blk_dec),
`endif
        .blk_ready   (blk_ready),
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_final    (dp_final),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
`ifdef AES_SCHED_DECRYPT_EN
        .dp_dec      (dp_dec),
`endif
        .key_valid   (key_valid),
        .key_err     (key_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in the KSTART cycle. km_ready keeps its old value through
    // KSTART and KWAIT0, then stays low for n_low more cycles before rising.
    task automatic key_wait(input int n_low);
        key_init = 1'b0;
        cyc();
        chk("kwait0_km_init", km_init, 0);
        chk("kwait0_key_valid", key_valid, 0);
        cyc();
        chk("kwait_first_key_valid", key_valid, 0);
        km_ready = 1'b0;
        for (int i = 0; i < n_low; i++) begin
            cyc();
            chk("kwait_key_valid", key_valid, 0);
        end
        km_ready = 1'b1;
        cyc();
        chk("kready_key_valid", key_valid, 1);
        chk("kready_blk_ready", blk_ready, 1);
        chk("kready_km_init", km_init, 0);
    endtask

    // Entered in the handshake cycle (cycle 0). Returns in the first OUT cycle.
    // rekey_at: cycle index at which a key_init pulse (keylen=1) is injected.
    task automatic run_block(input logic [3:0] nr, input bit dec, input int rekey_at);
        logic [3:0] exp_round;
        cyc();
        blk_valid = 1'b0;
        chk("load_dp_load", dp_load, 1);
        exp_round = dec ? nr : 4'd0;
        chk("load_km_round", km_round, exp_round);
        chk("load_round_en", dp_round_en, 0);
        chk("load_blk_ready", blk_ready, 0);
        chk("load_key_valid", key_valid, 1);
`ifdef AES_SCHED_DECRYPT_EN
        chk("load_dp_dec", dp_dec, dec);
`endif
        for (int c = 2; c <= int'(nr) + 1; c++) begin
            cyc();
            exp_round = dec ? nr - 4'(c - 1) : 4'(c - 1);
            chk("round_km_round", km_round, exp_round);
            chk("round_en", dp_round_en, 1);
            chk("round_final", dp_final, (c == int'(nr) + 1) ? 8'd1 : 8'd0);
            chk("round_dp_load", dp_load, 0);
            chk("round_res_valid", res_valid, 0);
            if (c == rekey_at) begin
                key_init = 1'b1;
                keylen   = 1'b1;
            end else begin
                key_init = 1'b0;
            end
        end
        cyc();
        key_init = 1'b0;
        chk("out_res_valid", res_valid, 1);
        chk("out_km_round", km_round, 0);
        chk("out_round_en", dp_round_en, 0);
        chk("out_final", dp_final, 0);
`ifdef AES_SCHED_DECRYPT_EN
        chk("out_dp_dec", dp_dec, dec);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        key_init  = 1'b0;
        keylen    = 1'b0;
        km_ready  = 1'b0;
        blk_valid = 1'b0;
        res_ready = 1'b0;
`ifdef AES_SCHED_DECRYPT_EN
        blk_dec   = 1'b0;
`endif

        // Reset
        cyc();
        cyc();
        chk("rst_km_init", km_init, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_blk_ready", blk_ready, 0);
        chk("rst_km_round", km_round, 0);
        chk("rst_dp_load", dp_load, 0);
        rst = 1'b0;

        // First key load, AES-128
        cyc();
        chk("nokey_km_init", km_init, 0);
        key_init = 1'b1;
        keylen   = 1'b0;
        cyc();
        chk("kstart_km_init", km_init, 1);
        key_wait(10);

        // AES-128 block, res_ready high
        blk_valid = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("blk128_blk_ready", blk_ready, 1);
        run_block(4'd10, 1'b0, -1);
        cyc();
        chk("blk128_res_done", res_valid, 0);
        chk("blk128_ready_again", blk_ready, 1);
        chk("blk128_no_km_init", km_init, 0);

        // Collision: key_init and blk_valid together, key_init wins (AES-256)
        key_init  = 1'b1;
        keylen    = 1'b1;
        blk_valid = 1'b1;
        #1;
        chk("collide_blk_ready", blk_ready, 0);
        cyc();
        blk_valid = 1'b0;
        chk("collide_km_init", km_init, 1);
        chk("collide_key_valid", key_valid, 0);
        chk("collide_dp_load", dp_load, 0);
        key_wait(3);

        // AES-256 block with backpressure; live keylen deliberately 0
        keylen    = 1'b0;
        blk_valid = 1'b1;
        res_ready = 1'b0;
        #1;
        chk("blk256_blk_ready", blk_ready, 1);
        run_block(4'd14, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            chk("bp_res_valid", res_valid, 1);
            chk("bp_blk_ready", blk_ready, 0);
            if (i == 5) res_ready = 1'b1;
        end
        cyc();
        chk("bp_res_done", res_valid, 0);
        chk("bp_ready_again", blk_ready, 1);

        // Timeout: km_ready stuck low
        key_init = 1'b1;
        keylen   = 1'b0;
        cyc();
        key_init = 1'b0;
        km_ready = 1'b0;
        chk("tmo_km_init", km_init, 1);
        for (int i = 1; i <= 32; i++) cyc();
        chk("tmo_before_err", key_err, 0);
        chk("tmo_before_key_valid", key_valid, 0);
        cyc();
        chk("tmo_key_err", key_err, 1);
        chk("tmo_key_valid", key_valid, 0);
        chk("tmo_km_init_idle", km_init, 0);
        blk_valid = 1'b1;
        #1;
        chk("tmo_nokey_blk_ready", blk_ready, 0);
        blk_valid = 1'b0;

        // Reload from NOKEY clears key_err
        key_init = 1'b1;
        keylen   = 1'b0;
        cyc();
        chk("reload_km_init", km_init, 1);
        chk("reload_key_err", key_err, 0);
        key_wait(12);

`ifdef AES_SCHED_DECRYPT_EN
        // Decrypt block, AES-128: round keys 10..0
        blk_valid = 1'b1;
        blk_dec   = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("dec_blk_ready", blk_ready, 1);
        run_block(4'd10, 1'b1, -1);
        blk_dec = 1'b0;
        cyc();
        chk("dec_res_done", res_valid, 0);
        chk("dec_dp_dec_clear", dp_dec, 0);
`endif

        // Rekey (keylen=1) at cycle 4 of an AES-128 block
        blk_valid = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("rekey_blk_ready", blk_ready, 1);
        run_block(4'd10, 1'b0, 4);
        keylen = 1'b0;
        chk("rekey_out_key_valid", key_valid, 1);
        cyc();
        chk("rekey_km_init", km_init, 1);
        chk("rekey_key_valid", key_valid, 0);
        chk("rekey_res_valid", res_valid, 0);
        key_wait(5);

        // The deferred rekey latched keylen=1: next block uses Nr=14
        blk_valid = 1'b1;
        #1;
        chk("post_rekey_blk_ready", blk_ready, 1);
        run_block(4'd14, 1'b0, -1);
        cyc();
        chk("post_rekey_res_done", res_valid, 0);
        chk("post_rekey_ready", blk_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
